// File: rtl/ga_pkg.sv
// Shared types and constants for the genetic-algorithm controller slice.
package ga_pkg;

  localparam int FIT_W    = 12;  // fitness word, matches the sorter input
  localparam int POP_SIZE = 50;  // individuals per generation
  localparam int IDX_W    = 6;   // index width covering POP_SIZE

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_SORT,
    S_CHECK,
    S_BREED,
    S_FINISH
  } ga_state_t;

endpackage

// File: rtl/ga_generation_sequencer_stage_watchdog.sv
// Per-stage timeout counter: restarts on stage entry, counts while the stage
// is outstanding and saturates at all-ones.
module stage_watchdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WDOG_W-1:0] LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  logic [WDOG_W-1:0] r_cnt;

  // Wait-cycle counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clear)                r_cnt <= '0;
    else if (i_enable && !(&r_cnt))  r_cnt <= r_cnt + WDOG_W'(1);
  end

  // Flag on the cycle the count steps onto all-ones, so the sequencer leaves
  // the stage on the very edge the counter saturates.
  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/ga_generation_sequencer.sv
// Generation sequencer for one GA run: EVAL -> SORT -> CHECK -> BREED loop,
// stopping on target fitness or generation limit. Optional stage watchdog
// is compiled in with GA_WATCHDOG_EN.
module ga_generation_sequencer
  import ga_pkg::*;
#(
  parameter int FIT_W  = ga_pkg::FIT_W,
  parameter int GEN_W  = 10,
  parameter int WDOG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_abort,
  input  logic [GEN_W-1:0] i_max_gen,
  input  logic [FIT_W-1:0] i_target_fit,
  input  logic [FIT_W-1:0] i_best_fit,
  output logic             o_eval_start,
  input  logic             i_eval_done,
  output logic             o_sort_start,
  input  logic             i_sort_done,
  output logic             o_breed_start,
  input  logic             i_breed_done,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_hit_target,
  output logic [GEN_W-1:0] o_gen_count,
  output logic             o_error
);

  ga_state_t        r_state, w_next;
  logic [GEN_W-1:0] r_max_gen, r_gen_count;
  logic [FIT_W-1:0] r_target_fit, r_best_fit_q;
  logic             r_hit_target, r_error;
  logic             r_eval_start, r_sort_start, r_breed_start, r_busy, r_done;
  logic             w_eval_start_d, w_sort_start_d, w_breed_start_d, w_busy_d, w_done_d;
  logic             w_in_stage, w_stage_done, w_wdog_expired;
  logic             w_fit_hit, w_gen_limit;

  assign w_in_stage  = (r_state == S_EVAL) || (r_state == S_SORT) || (r_state == S_BREED);
  assign w_fit_hit   = (r_best_fit_q >= r_target_fit);
  assign w_gen_limit = (r_gen_count == r_max_gen);

  // Stage completion, honoured only after the start pulse of the current state
  always_comb begin
    w_stage_done = 1'b0;
    case (r_state)
      S_EVAL:  w_stage_done = i_eval_done  && !r_eval_start;
      S_SORT:  w_stage_done = i_sort_done  && !r_sort_start;
      S_BREED: w_stage_done = i_breed_done && !r_breed_start;
      default: w_stage_done = 1'b0;
    endcase
  end

`ifdef GA_WATCHDOG_EN
  logic w_wd_clear;
  assign w_wd_clear = (w_next != r_state) &&
                      ((w_next == S_EVAL) || (w_next == S_SORT) || (w_next == S_BREED));

  stage_watchdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wd_clear),
    .i_enable  (w_in_stage),
    .o_expired (w_wdog_expired)
  );
`else
  // No watchdog: expiry never fires for any legal WDOG_W.
  assign w_wdog_expired = (WDOG_W < 1);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort beats any stage completion
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_run && !i_abort) w_next = S_EVAL;
        S_EVAL:   if (w_stage_done) w_next = S_SORT;
                  else if (w_wdog_expired) w_next = S_FINISH;
        S_SORT:   if (w_stage_done) w_next = S_CHECK;
                  else if (w_wdog_expired) w_next = S_FINISH;
        S_CHECK:  w_next = (w_fit_hit || w_gen_limit) ? S_FINISH : S_BREED;
        S_BREED:  if (w_stage_done) w_next = S_EVAL;
                  else if (w_wdog_expired) w_next = S_FINISH;
        S_FINISH: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state; starts fire only on state entry
  always_comb begin
    w_eval_start_d  = (w_next == S_EVAL)  && (r_state != S_EVAL);
    w_sort_start_d  = (w_next == S_SORT)  && (r_state != S_SORT);
    w_breed_start_d = (w_next == S_BREED) && (r_state != S_BREED);
    w_busy_d        = (w_next != S_IDLE);
    w_done_d        = (w_next == S_FINISH);
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_start  <= 1'b0;
      r_sort_start  <= 1'b0;
      r_breed_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_eval_start  <= w_eval_start_d;
      r_sort_start  <= w_sort_start_d;
      r_breed_start <= w_breed_start_d;
      r_busy        <= w_busy_d;
      r_done        <= w_done_d;
    end
  end

  // Run context: limits latched at acceptance, counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_gen    <= '0;
      r_target_fit <= '0;
      r_best_fit_q <= '0;
      r_gen_count  <= '0;
      r_hit_target <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next == S_EVAL) begin
        r_max_gen    <= i_max_gen;
        r_target_fit <= i_target_fit;
        r_gen_count  <= '0;
        r_hit_target <= 1'b0;
        r_error      <= 1'b0;
      end
      if (r_state == S_SORT && w_next == S_CHECK)
        r_best_fit_q <= i_best_fit;
      if (r_state == S_BREED && w_next == S_EVAL)
        r_gen_count <= r_gen_count + GEN_W'(1);
      if (r_state == S_CHECK && w_next == S_FINISH && w_fit_hit)
        r_hit_target <= 1'b1;
      if (w_in_stage && w_next == S_FINISH)
        r_error <= 1'b1;
    end
  end

  assign o_eval_start  = r_eval_start;
  assign o_sort_start  = r_sort_start;
  assign o_breed_start = r_breed_start;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_hit_target  = r_hit_target;
  assign o_gen_count   = r_gen_count;
  assign o_error       = r_error;

endmodule

// File: doc/ga_generation_sequencer.md
# ga_generation_sequencer

Top-level controller for one genetic-algorithm run. It sequences each generation through three datapath stages: fitness evaluation, then `PopSorter` (population ranking), then breeding/crossover. It counts generations and stops either when the best fitness reaches a target or when a generation limit is reached. It sits between the host-facing run/done handshake and the three stage engines, each of which exposes a one-cycle `start` pulse and a one-cycle `done` pulse.

## Interface
Parameters:
- `FIT_W`, 12, width of a fitness value (matches the sorter input word).
- `GEN_W`, 10, width of the generation counter and limit.
- `WDOG_W`, 16, width of the per-stage watchdog counter.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: one-cycle request to start a run. Accepted only in IDLE.
- `abort` in 1: synchronous abort of the current run.
- `max_gen` in GEN_W: generation limit, sampled when `run` is accepted.
- `target_fit` in FIT_W: fitness goal, sampled when `run` is accepted.
- `best_fit` in FIT_W: fitness of rank-0 individual, valid after `sort_done`.
- `eval_start` out 1 / `eval_done` in 1: fitness-evaluation handshake.
- `sort_start` out 1 / `sort_done` in 1: `PopSorter` handshake.
- `breed_start` out 1 / `breed_done` in 1: breeding-engine handshake.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `hit_target` out 1: the run ended because the target fitness was reached.
- `gen_count` out GEN_W: number of completed breeding passes.
- `error` out 1: a stage watchdog expired. Present only with `GA_WATCHDOG_EN`; otherwise tied to 0.

## Operation
- States: IDLE → EVAL → SORT → CHECK → BREED → EVAL …; a run ends via FINISH → IDLE.
- IDLE, on `run`:
  - latch `max_gen` and `target_fit`;
  - clear `gen_count`, `hit_target` and `error`;
  - go to EVAL.
- Entering EVAL, SORT or BREED: the matching `*_start` is high for exactly the first cycle in the state.
  - The stage's `*_done` is honoured only from the cycle after that start pulse.
  - A `*_done` arriving in any other state is ignored.
- EVAL, on `eval_done`: go to SORT.
- SORT, on `sort_done`: register `best_fit` and go to CHECK.
- CHECK (exactly one cycle), evaluated in this priority:
  1. `best_fit_q >= target_fit` (unsigned) → FINISH with `hit_target`=1.
  2. Else `gen_count == max_gen` → FINISH with `hit_target`=0.
  3. Else → BREED.
- BREED, on `breed_done`: increment `gen_count`, then go to EVAL.
- FINISH: `done` pulses for one cycle, then IDLE. `gen_count` and `hit_target` hold until the next accepted `run`.
- `max_gen`=0: one evaluation and one sort only; no breeding pass.
- `abort` in any non-IDLE state → IDLE on the next edge.
  - No `done` pulse; all `*_start` outputs low.
  - `abort` has priority over a simultaneous `*_done`.
- `run` while `busy` is ignored. `run` and `abort` together in IDLE: `abort` wins, so the run is not started.

## Timing
- Reset values:
  - state IDLE;
  - all `*_start`, `busy`, `done`, `hit_target` and `error` = 0;
  - `gen_count` = 0.
- All outputs are registered.
- Latencies:
  - `run` at edge t → `busy` and `eval_start` high at t+1.
  - `eval_done` at t → `sort_start` at t+1.
  - `sort_done` at t → CHECK at t+1 → `breed_start` or FINISH at t+2.
  - `done` is high in the FINISH cycle; `busy` falls with it on the following edge.
- Sequencer overhead is 4 cycles per generation, excluding stage latencies.
- Reset assertion mid-run returns the block to IDLE immediately, without waiting for a clock edge.

## Configuration
- `GA_WATCHDOG_EN` defined:
  - a WDOG_W-bit counter clears on entry to EVAL, SORT or BREED and increments each cycle while waiting;
  - when it reaches all-ones: `error`=1, FINISH (`done` pulses, `hit_target`=0), then IDLE;
  - `error` holds until the next accepted `run` or reset.
- Undefined: stages may wait indefinitely; `error` is constant 0 and the counter is not synthesised.

## Structure
- Shared package `ga_pkg` holds:
  - `FIT_W`, the population size (50) and the index width (6);
  - the state enumeration `ga_state_t`.
- One sub-module, `stage_watchdog` (clear, enable, expired), instantiated only under `GA_WATCHDOG_EN`.

## Test plan
- Nominal target hit: `max_gen`=5, `target_fit`=0x300; stub stages reply `done` 3 cycles after start; `best_fit` =0x100 then 0x200 then 0x350 → `done` after the third sort, `hit_target`=1, `gen_count`=2.
- Generation limit: `max_gen`=3, `best_fit` fixed at 0x010 → exactly 4 `eval_start` and 3 `breed_start` pulses; then `done`, `hit_target`=0, `gen_count`=3.
- Zero limit: `max_gen`=0 → one eval and one sort, no `breed_start`, `done` with `gen_count`=0.
- Abort during SORT, coincident with `sort_done` → IDLE next cycle, no `done`, no `breed_start`; a fresh `run` restarts with `gen_count`=0.
- Handshake robustness: `run` pulsed while busy, and a spurious `breed_done` during EVAL → both ignored; the sequence is unchanged.
- Watchdog (`GA_WATCHDOG_EN`, `WDOG_W`=4): `sort_done` never arrives → 15 cycles after `sort_start`, `error`=1 and `done` pulses; the next `run` clears `error`.
